// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the shared-datapath control lines. Memory accesses wait on mem_ready,
// with an optional timeout that parks the FSM in FAULT until reset.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   instr_op[5:0]     opcode field IR[31:26]
//   mem_ready         memory completes the current access this cycle
//   PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp, PCSource[1:0],
//   Sign              datapath controls (combinational from state/op/mem_ready)
//   state[3:0]        current state encoding
//   fault[1:0]        00 none, 01 illegal opcode, 10 memory timeout
//
// Optional feature: define MC_CONTROL_BNE_EN to decode bne (000101) into
// BRANCH with PCWriteCondNe; otherwise bne is an illegal opcode.
module mc_control_fsm #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         instr_op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCWriteCondNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               Sign,
    output logic [3:0]         state,
    output logic [1:0]         fault
);

    if (ALUOP_W != 2) begin : g_aluop_w_check
        $error("mc_control_fsm: only ALUOP_W=2 is supported");
    end
    if (TIMEOUT > 255) begin : g_timeout_check
        $error("mc_control_fsm: TIMEOUT must be in 0..255");
    end

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_FAULT  = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CONTROL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // Count value held on the last permitted wait cycle; the cycle that would
    // make it TIMEOUT consecutive waits is the one that faults.
    localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 1 : TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] fault_q, fault_d;
    logic [1:0] aluop_c;
    logic       in_wait;
    logic       timed_out;

    assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timed_out = (TIMEOUT != 0) && in_wait && !mem_ready && (wait_q == TO_LAST);
    assign ALUOp     = aluop_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        wait_d        = '0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        aluop_c       = 2'b00;
        PCSource      = 2'b00;
        Sign          = 1'b0;
        state         = state_q;
        fault         = fault_q;

        // Counter is zero in every non-wait state, so each access starts at 0.
        if (in_wait && !mem_ready) begin
            wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        end

        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                    fault_d = 2'b10;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (instr_op)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = S_RTEX;
                    OP_ADDI, OP_ANDI: state_d = S_IMMEX;
                    OP_BEQ:           state_d = S_BRANCH;
`ifdef MC_CONTROL_BNE_EN
                    OP_BNE:           state_d = S_BRANCH;
`endif
                    OP_J:             state_d = S_JUMP;
                    default: begin
                        state_d = S_FAULT;
                        fault_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (instr_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                    fault_d = 2'b10;
                end
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                    fault_d = 2'b10;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_RTEX: begin
                ALUSrcA = 1'b1;
                aluop_c = 2'b10;
                state_d = S_RTWB;
            end
            S_RTWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (instr_op == OP_ANDI) begin
                    aluop_c = 2'b11;
                    Sign    = 1'b1;
                end
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
                if (instr_op == OP_ANDI) begin
                    aluop_c = 2'b11;
                    Sign    = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                aluop_c  = 2'b01;
                PCSource = 2'b01;
`ifdef MC_CONTROL_BNE_EN
                if (instr_op == OP_BNE) PCWriteCondNe = 1'b1;
                else                    PCWriteCond   = 1'b1;
`else
                PCWriteCond = 1'b1;
`endif
                state_d = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset blanks every output in the same cycle it is asserted.
        if (reset) begin
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            PCWriteCondNe = 1'b0;
            IorD          = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            MemtoReg      = 1'b0;
            RegDst        = 1'b0;
            RegWrite      = 1'b0;
            ALUSrcA       = 1'b0;
            ALUSrcB       = 2'b00;
            aluop_c       = 2'b00;
            PCSource      = 2'b00;
            Sign          = 1'b0;
            state         = 4'd0;
            fault         = 2'b00;
        end
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS control unit; next generation of the single-cycle opcode decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives the shared-datapath control lines.
- Handshakes with a variable-latency unified memory via mem_ready, with a wait timeout.
- Sits between the instruction register (opcode field) and the multicycle datapath.

Parameters:
- TIMEOUT, 16, consecutive mem_ready-low wait cycles before fault; 0 disables the timeout; legal range 0..255.
- ALUOP_W, 2, ALUOp width; only 2 is supported, other values are an elaboration error.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- instr_op  in  6  opcode from IR[31:26]
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write if ALU zero (beq)
- PCWriteCondNe  out  1  PC write if ALU not-zero (bne; 0 unless BNE_EN)
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  writeback source is MDR
- RegDst  out  1  destination is rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=4, 10=ext imm, 11=ext imm<<2
- ALUOp  out  ALUOP_W  00=add, 01=sub, 10=funct, 11=and
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- Sign  out  1  1=zero-extend imm (andi), 0=sign-extend
- state  out  4  current state encoding
- fault  out  2  00=none, 01=illegal opcode, 10=memory timeout

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11, FAULT=15.
- Control outputs are combinational from state, instr_op and mem_ready. Any output not listed for a state is 0.
- Reset: while reset=1, every output is 0 (state output forced to 0). On the reset edge: state<=FETCH, wait counter<=0, fault<=00. Reset has priority in any state, including mid-wait and FAULT.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by instr_op:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 -> RTEX
  - 001000 addi or 001100 andi -> IMMEX
  - 000100 beq -> BRANCH
  - 000010 j -> JUMP
  - anything else -> FAULT with fault=01
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Sign=0. Next: MEMRD for lw, MEMWR for sw. instr_op is held stable by the IR.
- MEMRD: MemRead=1, IorD=1. Advance to MEMWB on mem_ready.
- MEMWR: MemWrite=1, IorD=1. Return to FETCH on mem_ready.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RTWB.
- RTWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10.
  - addi: ALUOp=00, Sign=0.
  - andi: ALUOp=11, Sign=1.
  - Next state IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0, with Sign/ALUOp held as in IMMEX -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- Wait counter (8 bit):
  - Cleared on entry to FETCH, MEMRD or MEMWR, and whenever mem_ready=1.
  - Increments on each cycle in those states with mem_ready=0.
  - If TIMEOUT!=0 and a cycle is the TIMEOUT-th consecutive mem_ready=0 cycle: next state FAULT, fault<=10. IRWrite, PCWrite and RegWrite are never asserted for that access.
  - Counter saturates at 255.
- FAULT: all controls 0; fault holds its value. Exit only via reset. mem_ready is ignored.
- mem_ready outside FETCH, MEMRD or MEMWR is ignored.
- Latency (mem_ready=1 on first request cycle):
  - lw: 5 cycles
  - sw, R-type, addi, andi: 4 cycles
  - beq, j: 3 cycles
  - Each wait cycle adds 1.

Optional Feature:
- Macro: MC_CONTROL_BNE_EN.
- Defined: opcode 000101 (bne) in DECODE -> BRANCH. In BRANCH, PCWriteCondNe=1 and PCWriteCond=0 for bne; beq unchanged.
- Undefined: 000101 is illegal (FAULT, fault=01), and PCWriteCondNe is tied 0.

Test Plan:
- Reset held 3 cycles mid-MEMRD -> all outputs 0 during reset; state=0, fault=00 the cycle after reset falls; MemRead=1.
- lw (100011), mem_ready always 1 -> states 0,1,2,3,4,0 over 5 cycles; MemtoReg=RegWrite=1 only in state 4.
- andi (001100) -> IMMEX/IMMWB with ALUOp=11, Sign=1, RegDst=0; addi (001000) gives ALUOp=00, Sign=0; 4 cycles each.
- sw with mem_ready low 3 cycles in MEMWR, TIMEOUT=16 -> MemWrite=1, IorD=1 for 4 cycles, then FETCH, fault=00.
- FETCH with mem_ready low 16 cycles, TIMEOUT=16 -> state=15, fault=10 on the 17th cycle, IRWrite never 1; recovers only after reset.
- Opcode 000101 -> without the macro: state=15, fault=01. With MC_CONTROL_BNE_EN: BRANCH with PCWriteCondNe=1, ALUOp=01, PCSource=01.
